// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multi-cycle fetch/decode/execute sequencer for the CID2
// accumulator core. Drives PC/IR/ALU/accumulator/zero-flag enables, owns the
// memory request handshake with a bus timeout, and resolves JMPZ from the
// registered zero flag.
//
// Build option: define CORE_CTRL_ILLEGAL_TRAP_EN to trap opcodes A-E into
// HALTED and expose the sticky illegal_op output. Without it those opcodes
// execute as NOP and illegal_op does not exist.
module core_ctrl_fsm #(
    parameter int unsigned OPCODE_W    = 4,
    parameter int unsigned ALU_OP_W    = 3,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                addr_sel,
    output logic                ir_load,
    output logic                pc_inc,
    output logic                pc_load,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                acc_we,
    output logic                zflag_we,
    output logic                halted,
    output logic                bus_err
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                illegal_op
`endif
);

    // Opcode map
    localparam logic [OPCODE_W-1:0] OP_NOP   = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_LOAD  = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_STORE = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_ADD   = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_SUB   = OPCODE_W'(4);
    localparam logic [OPCODE_W-1:0] OP_AND   = OPCODE_W'(5);
    localparam logic [OPCODE_W-1:0] OP_OR    = OPCODE_W'(6);
    localparam logic [OPCODE_W-1:0] OP_XOR   = OPCODE_W'(7);
    localparam logic [OPCODE_W-1:0] OP_JMP   = OPCODE_W'(8);
    localparam logic [OPCODE_W-1:0] OP_JMPZ  = OPCODE_W'(9);
    localparam logic [OPCODE_W-1:0] OP_HALT  = OPCODE_W'(15);

    // ALU opcodes ADD..XOR map onto alu_op 1..5 by subtracting this base
    localparam logic [OPCODE_W-1:0] ALU_BASE = OPCODE_W'(2);
    localparam logic [ALU_OP_W-1:0] ALU_PASS = '0;

    // Timeout counter holds 0 .. MEM_TIMEOUT-1 waiting cycles
    localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST =
        CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_HALTED
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             tmo_expire;
    logic             is_mem_op;
    state_t           done_next;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    logic             illegal_hit;
`endif

    // Timeout fires on the last permitted waiting cycle; disabled when 0
    assign tmo_hit   = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
    assign is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign done_next = run ? S_FETCH : S_IDLE;

    // State, timeout counter and sticky error registers
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            state <= state_next;
            // Any state change clears the counter, so it is zero on entry
            // to FETCH or MEM, including the direct MEM -> FETCH path.
            if (state_next != state) begin
                tmo_cnt <= '0;
            end else if (mem_req && !mem_ready) begin
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
            if (tmo_expire) begin
                bus_err <= 1'b1;
            end
        end
    end

`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    // Sticky record of an illegal opcode reaching EXEC
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            illegal_op <= 1'b0;
        end else if (illegal_hit) begin
            illegal_op <= 1'b1;
        end
    end
`endif

    // Next-state and output decode from state, opcode, flag and handshake
    always_comb begin
        state_next = state;
        tmo_expire = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        addr_sel   = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        alu_op     = ALU_PASS;
        acc_we     = 1'b0;
        zflag_we   = 1'b0;
        halted     = 1'b0;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
        illegal_hit = 1'b0;
`endif

        case (state)
            S_IDLE: begin
                if (run) begin
                    state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req = 1'b1;
                // A ready on the expiry cycle still completes the fetch
                if (mem_ready) begin
                    ir_load    = 1'b1;
                    pc_inc     = 1'b1;
                    state_next = S_DECODE;
                end else if (tmo_hit) begin
                    tmo_expire = 1'b1;
                    state_next = S_HALTED;
                end
            end

            S_DECODE: begin
                state_next = is_mem_op ? S_MEM : S_EXEC;
            end

            S_EXEC: begin
                state_next = done_next;
                case (opcode)
                    OP_NOP: begin
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                        alu_op   = ALU_OP_W'(opcode - ALU_BASE);
                        acc_we   = 1'b1;
                        zflag_we = 1'b1;
                    end
                    OP_JMP: begin
                        pc_load = 1'b1;
                    end
                    OP_JMPZ: begin
                        pc_load = zero_flag;
                    end
                    OP_HALT: begin
                        state_next = S_HALTED;
                    end
                    default: begin
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
                        illegal_hit = 1'b1;
                        state_next  = S_HALTED;
`endif
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (opcode == OP_STORE);
                if (mem_ready) begin
                    if (opcode == OP_LOAD) begin
                        alu_op   = ALU_PASS;
                        acc_we   = 1'b1;
                        zflag_we = 1'b1;
                    end
                    state_next = done_next;
                end else if (tmo_hit) begin
                    tmo_expire = 1'b1;
                    state_next = S_HALTED;
                end
            end

            S_HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: directed-vector bench for core_ctrl_fsm. The stimulus
// process pushes the expected output vector for each cycle it drives, tagged
// with the cycle number; a monitor pops and compares on the falling edge.
module tb_core_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic       ir_load;
        logic       pc_inc;
        logic       pc_load;
        logic [2:0] alu_op;
        logic       acc_we;
        logic       zflag_we;
        logic       halted;
        logic       bus_err;
    } outs_t;

    typedef struct {
        int unsigned cyc;
        outs_t       o;
        string       tag;
    } exp_t;

    localparam outs_t Z = '0;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       run;
    logic [3:0] opcode;
    logic       zero_flag;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_we;
    logic       addr_sel;
    logic       ir_load;
    logic       pc_inc;
    logic       pc_load;
    logic [2:0] alu_op;
    logic       acc_we;
    logic       zflag_we;
    logic       halted;
    logic       bus_err;
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    exp_t        sb[$];
    int unsigned cyc    = 0;
    logic        mon_en = 1'b0;
    int          n_cmp  = 0;
    int          n_bad  = 0;

    core_ctrl_fsm #(
        .OPCODE_W   (4),
        .ALU_OP_W   (3),
        .MEM_TIMEOUT(16)
    ) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .run      (run),
        .opcode   (opcode),
        .zero_flag(zero_flag),
        .mem_ready(mem_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .addr_sel (addr_sel),
        .ir_load  (ir_load),
        .pc_inc   (pc_inc),
        .pc_load  (pc_load),
        .alu_op   (alu_op),
        .acc_we   (acc_we),
        .zflag_we (zflag_we),
        .halted   (halted),
        .bus_err  (bus_err)
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op(illegal_op)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: compare on the falling edge; any active output with no
    // expectation queued for this cycle is also an error
    always @(negedge clock) begin
        outs_t got;
        exp_t  e;
        got = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
               alu_op, acc_we, zflag_we, halted, bus_err};
        if (mon_en) begin
            if (sb.size() != 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                n_cmp++;
                if (got !== e.o) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%b exp=%b (req,we,asel,irl,pci,pcl,alu3,acc,zfw,hlt,berr)",
                             e.tag, cyc, got, e.o);
                end
            end else if (got !== Z) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output cyc=%0d got=%b exp=%b", cyc, got, Z);
            end
        end
    end

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = '0;
        o.mem_req = 1'b1;
        o.ir_load = rdy;
        o.pc_inc  = rdy;
        return o;
    endfunction

    function automatic outs_t o_alu(input logic [2:0] a);
        outs_t o = '0;
        o.alu_op   = a;
        o.acc_we   = 1'b1;
        o.zflag_we = 1'b1;
        return o;
    endfunction

    function automatic outs_t o_pcl(input logic l);
        outs_t o = '0;
        o.pc_load = l;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic we, input logic ld);
        outs_t o = '0;
        o.mem_req  = 1'b1;
        o.addr_sel = 1'b1;
        o.mem_we   = we;
        o.acc_we   = ld;
        o.zflag_we = ld;
        return o;
    endfunction

    function automatic outs_t o_halt(input logic berr);
        outs_t o = '0;
        o.halted  = 1'b1;
        o.bus_err = berr;
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the outputs expected in that cycle
    task automatic drive(input logic r, input logic [3:0] op, input logic zf,
                         input logic rdy, input outs_t e, input string tag);
        exp_t x;
        run       = r;
        opcode    = op;
        zero_flag = zf;
        mem_ready = rdy;
        x.cyc = cyc;
        x.o   = e;
        x.tag = tag;
        sb.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic exec_instr(input logic [3:0] op, input logic zf, input outs_t e_exec,
                              input logic r_end, input string tag);
        drive(1'b1, op, zf, 1'b1, o_fetch(1'b1), {tag, "_fetch"});
        drive(1'b1, op, zf, 1'b1, Z, {tag, "_decode"});
        drive(r_end, op, zf, 1'b1, e_exec, {tag, "_exec"});
    endtask

    task automatic mem_instr(input logic [3:0] op, input int waits, input logic ld,
                             input logic we, input string tag);
        drive(1'b1, op, 1'b0, 1'b1, o_fetch(1'b1), {tag, "_fetch"});
        drive(1'b1, op, 1'b0, 1'b1, Z, {tag, "_decode"});
        for (int i = 0; i < waits; i++)
            drive(1'b1, op, 1'b0, 1'b0, o_mem(we, 1'b0), {tag, "_wait"});
        drive(1'b1, op, 1'b0, 1'b1, o_mem(we, ld), {tag, "_done"});
    endtask

    initial begin
        reset_n   = 1'b0;
        run       = 1'b1;
        opcode    = 4'h0;
        zero_flag = 1'b0;
        mem_ready = 1'b1;
        @(posedge clock);
        #1;
        mon_en = 1'b1;

        // Reset held for two edges with run=1: all outputs 0, then FETCH
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "reset_hold");
        reset_n = 1'b1;
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "reset_idle");

        // ALU and branch instructions, zero-wait memory
        exec_instr(4'h3, 1'b0, o_alu(3'd1), 1'b1, "add");
        exec_instr(4'h4, 1'b0, o_alu(3'd2), 1'b1, "sub_to_zero");
        exec_instr(4'h9, 1'b1, o_pcl(1'b1), 1'b1, "jmpz_taken");
        exec_instr(4'h3, 1'b1, o_alu(3'd1), 1'b1, "add_to_5");
        exec_instr(4'h9, 1'b0, o_pcl(1'b0), 1'b1, "jmpz_not_taken");
        exec_instr(4'h8, 1'b0, o_pcl(1'b1), 1'b1, "jmp");
        exec_instr(4'h5, 1'b0, o_alu(3'd3), 1'b1, "and");
        exec_instr(4'h6, 1'b0, o_alu(3'd4), 1'b1, "or");
        exec_instr(4'h7, 1'b0, o_alu(3'd5), 1'b1, "xor");
        exec_instr(4'h0, 1'b1, Z, 1'b1, "nop");

        // LOAD with ready delayed 3 cycles, then a zero-wait STORE
        mem_instr(4'h1, 3, 1'b1, 1'b0, "load_wait3");
        mem_instr(4'h2, 0, 1'b0, 1'b1, "store");

        // Delayed fetch, then NOP completing with run=0 -> IDLE
        drive(1'b1, 4'h0, 1'b0, 1'b0, o_fetch(1'b0), "fetch_wait");
        drive(1'b1, 4'h0, 1'b0, 1'b0, o_fetch(1'b0), "fetch_wait");
        drive(1'b1, 4'h0, 1'b0, 1'b1, o_fetch(1'b1), "fetch_late");
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "nop_decode");
        drive(1'b0, 4'h0, 1'b0, 1'b1, Z, "nop_exec_run0");
        drive(1'b0, 4'h0, 1'b0, 1'b1, Z, "idle_ready_ignored");
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "idle_run");

        // Ready arriving on the expiry cycle completes the LOAD
        mem_instr(4'h1, 15, 1'b1, 1'b0, "load_ready_at_expiry");

        // Reset mid-fetch: mem_req drops the cycle after the reset edge
        drive(1'b1, 4'h0, 1'b0, 1'b0, o_fetch(1'b0), "fetch_wait_pre_reset");
        reset_n = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b0, o_fetch(1'b0), "fetch_reset_edge");
        reset_n = 1'b1;
        drive(1'b0, 4'h0, 1'b0, 1'b0, Z, "post_reset_idle");
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "idle_run2");

        // HALT: stays halted until reset
        exec_instr(4'hF, 1'b0, Z, 1'b1, "halt");
        drive(1'b1, 4'h0, 1'b0, 1'b1, o_halt(1'b0), "halted");
        drive(1'b1, 4'h0, 1'b0, 1'b1, o_halt(1'b0), "halted_hold");
        reset_n = 1'b0;
        drive(1'b1, 4'h0, 1'b0, 1'b1, o_halt(1'b0), "halted_reset_edge");
        reset_n = 1'b1;
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "idle_after_halt");

        // Bus timeout: 16 waiting cycles in MEM -> halted with bus_err
        drive(1'b1, 4'h1, 1'b0, 1'b1, o_fetch(1'b1), "tmo_fetch");
        drive(1'b1, 4'h1, 1'b0, 1'b1, Z, "tmo_decode");
        for (int i = 0; i < 16; i++)
            drive(1'b1, 4'h1, 1'b0, 1'b0, o_mem(1'b0, 1'b0), "tmo_wait");
        drive(1'b1, 4'h1, 1'b0, 1'b1, o_halt(1'b1), "tmo_halted");
        reset_n = 1'b0;
        drive(1'b1, 4'h1, 1'b0, 1'b1, o_halt(1'b1), "tmo_reset_edge");
        reset_n = 1'b1;
        drive(1'b1, 4'h0, 1'b0, 1'b1, Z, "bus_err_cleared");

        // Illegal opcode 0xB
        exec_instr(4'hB, 1'b0, Z, 1'b1, "illegal_b");
`ifdef CORE_CTRL_ILLEGAL_TRAP_EN
        chk("illegal_op_set", {31'd0, illegal_op}, 32'd1);
        drive(1'b1, 4'hB, 1'b0, 1'b1, o_halt(1'b0), "illegal_halted");
        reset_n = 1'b0;
        drive(1'b1, 4'hB, 1'b0, 1'b1, o_halt(1'b0), "illegal_reset_edge");
        reset_n = 1'b1;
        chk("illegal_op_cleared", {31'd0, illegal_op}, 32'd0);
`else
        drive(1'b1, 4'h0, 1'b0, 1'b1, o_fetch(1'b1), "illegal_as_nop_fetch");
        reset_n = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b1, Z, "decode_reset_edge");
        reset_n = 1'b1;
`endif
        drive(1'b0, 4'h0, 1'b0, 1'b1, Z, "final_idle");

        chk("scoreboard_drained", sb.size(), 32'd0);
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
